// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder controller.
// The requester drives start and the operands; the controller returns status and result.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;

  modport master (
    output start, a_in, b_in, cin_in,
    input  busy, done, sum_out, cout_out
  );

  modport slave (
    input  start, a_in, b_in, cin_in,
    output busy, done, sum_out, cout_out
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: feeds one full-adder cell an LSB-first bit pair per
// clock with the registered carry, collects the sum bits and pulses done when finished.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_adder_ctrl_if.slave   bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_out_q, sum_out_d;
  logic             cout_out_q, cout_out_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH:0]   sum_shift;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Shifting through a WIDTH+1 vector keeps the update legal when WIDTH is 1.
  assign sum_shift = {fa_sum, sum_sh_q};

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    sum_sh_d   = sum_sh_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    sum_out_d  = sum_out_q;
    cout_out_d = cout_out_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d   = bus.a_in;
          b_sh_d   = bus.b_in;
          carry_d  = bus.cin_in;
          sum_sh_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sum_sh_d = sum_shift[WIDTH:1];
        carry_d  = fa_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          sum_out_d  = sum_shift[WIDTH:1];
          cout_out_d = fa_cout;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      sum_sh_q   <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      sum_out_q  <= '0;
      cout_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      sum_sh_q   <= sum_sh_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      sum_out_q  <= sum_out_d;
      cout_out_q <= cout_out_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.sum_out  = sum_out_q;
  assign bus.cout_out = cout_out_q;
endmodule
